// File: rtl/register_writeback_queue.sv
// Writeback queue: buffers {index, data} requests and drives the register file write port, one write per clock.
// Latency: 2 edges from handshake to write_signal (1 into an empty queue when WRITEBACK_BYPASS_EN is defined).
// Backpressure: request_ready low while full or in reset, no pop lookahead; index-0 requests are accepted and dropped.
module register_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     request_valid,
    output logic                     request_ready,
    input  logic [4:0]               request_register_index,
    input  logic [31:0]              request_data,
    output logic [4:0]               write_register_index,
    output logic [31:0]              write_data,
    output logic                     write_signal,
    output logic [$clog2(DEPTH):0]   occupancy,
    input  logic [4:0]               query_register_index,
    output logic                     query_hit
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    typedef struct packed {
        logic [4:0]  index;
        logic [31:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;

    logic            accept;
    logic            accept_nonzero;
    logic            bypass;
    logic            push;
    logic            pop;

    assign request_ready  = reset_n && (count != FULL_COUNT);
    assign accept         = request_valid && request_ready;
    assign accept_nonzero = accept && (request_register_index != 5'd0);
    assign pop            = (count != '0);

`ifdef WRITEBACK_BYPASS_EN
    // Only an empty queue may be bypassed, otherwise the request would overtake older entries.
    assign bypass = accept_nonzero && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push      = accept_nonzero && !bypass;
    assign occupancy = count;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= '{index: request_register_index, data: request_data};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr               <= '0;
            wr_ptr               <= '0;
            count                <= '0;
            write_signal         <= 1'b0;
            write_register_index <= 5'd0;
            write_data           <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                write_signal         <= 1'b1;
                write_register_index <= mem[rd_ptr].index;
                write_data           <= mem[rd_ptr].data;
            end else if (bypass) begin
                write_signal         <= 1'b1;
                write_register_index <= request_register_index;
                write_data           <= request_data;
            end else begin
                write_signal         <= 1'b0;
                write_register_index <= 5'd0;
                write_data           <= 32'd0;
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    logic [PW-1:0] slot_offset;
    logic          stored_hit;

    always_comb begin
        stored_hit  = 1'b0;
        slot_offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_offset = PW'(i) - rd_ptr;
            if (({1'b0, slot_offset} < count) && (mem[i].index == query_register_index)) begin
                stored_hit = 1'b1;
            end
        end
    end

    assign query_hit = (query_register_index != 5'd0) &&
                       (stored_hit || (write_signal && (write_register_index == query_register_index)));

endmodule
